sd_cmd_arbiter: RTL and testbench
=================================

Name: sd_cmd_arbiter

Overview:
- N-channel command arbiter for the SD-over-SPI command path.
- Sits between the command producers (disk manager, card initialiser, future DMA/multi-block engines) and the CRC/prepare stage.
- Replaces the OR-merge of producer buses with real arbitration, a per-channel request/accept/complete handshake and a response timeout.
- Exactly one producer owns the downstream command bus at any time.

Parameters:
NCH, 2, number of requesting channels (1..8)
CMD_W, 6, SD command index width
ARG_W, 32, SD command argument width
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 65535, cycles to wait for downstream completion before error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NCH  per-channel request, held high until req_ready
req_cmd  in  NCH*CMD_W  per-channel command index, channel i at [i*CMD_W +: CMD_W]
req_arg  in  NCH*ARG_W  per-channel argument, channel i at [i*ARG_W +: ARG_W]
req_kind  in  NCH  0 = plain start (sta), 1 = start with 40-bit frame (sta40)
req_readit  in  NCH  command expects a data read phase
req_init  in  NCH  command issued in init mode (slow clock / CS handling)
req_ready  out  NCH  one-cycle accept pulse to the granted channel
done  out  NCH  one-cycle completion pulse to the owner
err  out  NCH  one-cycle timeout pulse to the owner
cmd  out  CMD_W  granted command index
arg  out  ARG_W  granted argument
sta  out  1  one-cycle start pulse (req_kind = 0)
sta40  out  1  one-cycle start pulse (req_kind = 1)
readit  out  1  level, owner's readit
init  out  1  level, owner's init
abort  out  1  one-cycle pulse on timeout
busy  out  1  high whenever state is not IDLE
cmd_rdy  in  1  downstream completion strobe

Behaviour:
- Reset values: all outputs 0; state IDLE; owner index 0; RR pointer NCH-1, so channel 0 wins first; timeout counter 0.
- Reset mid-operation: the in-flight command is dropped silently; no done or err is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_valid bit is high at edge t, choose winner g and register owner=g, cmd/arg/readit/init from channel g; go to ISSUE. No request: stay in IDLE.
- ISSUE (cycle t+1):
  - req_ready[g]=1.
  - sta=1 if req_kind[g]=0, else sta40=1.
  - Go to WAIT, clear the counter.
- WAIT:
  - cmd, arg, readit and init are held stable.
  - cmd_rdy is sampled only in WAIT; a cmd_rdy in IDLE/ISSUE/DONE is ignored.
  - On cmd_rdy: go to DONE with success.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to DONE with failure and pulse abort.
  - Else: increment the counter (width clog2(TIMEOUT+1), saturating).
- cmd_rdy and timeout in the same cycle: cmd_rdy wins; done, no err, no abort.
- DONE (one cycle):
  - done[owner]=1 on success, err[owner]=1 on failure.
  - cmd, arg, readit, init return to 0.
  - Go to IDLE.
- Throughput: a new grant is possible at the edge after DONE. Latency from request to sta is 1 cycle from IDLE.
- Fixed priority: g = lowest set index.
- Round-robin: search starts at (ptr+1) mod NCH and wraps. ptr is updated to g at grant time, so the winner has lowest priority next arbitration.
- A request dropped before req_ready is simply not seen. A request re-asserted in the DONE cycle is sampled in the next IDLE.
- req_* inputs of non-owner channels are ignored while busy.
- Only one bit of req_ready/done/err is ever set; done and err are never set together.

Test Plan:
- Single channel: ch1 requests cmd=17, arg=0x00000200, kind=0, readit=1; cmd_rdy 5 cycles after sta -> sta pulses 1 cycle after req_valid, cmd=17/arg=0x200/readit=1 held through WAIT, then done[1] pulse and outputs back to 0.
- Round-robin fairness: NCH=3, all req_valid held high, cmd_rdy 2 cycles after each sta -> grant order 0,1,2,0,1,2; each req_ready is one cycle; no channel is granted twice in a row.
- Fixed priority: ARB_MODE=0, ch0 and ch1 both held -> ch0 is granted every time and ch1 is starved while ch0 keeps requesting.
- Timeout: TIMEOUT=8, ch0 kind=1 request, no cmd_rdy -> sta40 pulse, then exactly 8 WAIT cycles, abort plus err[0] in the same DONE cycle, no done[0].
- Tie: TIMEOUT=8, cmd_rdy asserted on the 8th WAIT cycle -> done[0]=1, err=0, abort=0.
- Reset mid-WAIT: rst asserted while ch1 is the owner -> all outputs 0 immediately; no done/err; the next request is granted to ch0 first.

Source files
------------

// File: rtl/sd_cmd_arbiter.sv
// N-channel command arbiter for the SD-over-SPI command path.
// One producer owns the downstream command bus from grant until done/err.
// Selection is fixed priority (lowest index) or round-robin; a stalled
// downstream is bounded by an optional response timeout.
//
// state | meaning
// IDLE  | no owner, arbitrating among req_valid
// ISSUE | accept pulse to owner, sta/sta40 pulse downstream
// WAIT  | command in flight, waiting for cmd_rdy or timeout
// DONE  | done/err (and abort on timeout) pulse to owner, bus cleared
module sd_cmd_arbiter #(
  parameter int NCH      = 2,
  parameter int CMD_W    = 6,
  parameter int ARG_W    = 32,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*CMD_W-1:0] req_cmd,
  input  logic [NCH*ARG_W-1:0] req_arg,
  input  logic [NCH-1:0]       req_kind,
  input  logic [NCH-1:0]       req_readit,
  input  logic [NCH-1:0]       req_init,
  output logic [NCH-1:0]       req_ready,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       err,
  output logic [CMD_W-1:0]     cmd,
  output logic [ARG_W-1:0]     arg,
  output logic                 sta,
  output logic                 sta40,
  output logic                 readit,
  output logic                 init,
  output logic                 abort,
  output logic                 busy,
  input  logic                 cmd_rdy
);

  localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [OW-1:0] PTR_RST  = OW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     owner, rr_ptr, win;
  logic [NCH-1:0]    owner_oh;
  logic              any_req;
  logic              timeout_hit;
  logic [CW-1:0]     cnt;
  logic              kind_q, ok_q, readit_q, init_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [ARG_W-1:0]  arg_q;

  assign owner_oh    = NCH'(1) << owner;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign cmd         = cmd_q;
  assign arg         = arg_q;
  assign readit      = readit_q;
  assign init        = init_q;

  // Winner selection; loops run backwards so the first match in search order wins.
  always_comb begin
    win     = '0;
    any_req = |req_valid;
    if (ARB_MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (req_valid[i]) win = OW'(i);
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        int idx;
        idx = (int'(rr_ptr) + k) % NCH;
        if (req_valid[idx]) win = OW'(idx);
      end
    end
  end

  // Next-state decode and per-state output pulses.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    done      = '0;
    err       = '0;
    sta       = 1'b0;
    sta40     = 1'b0;
    abort     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        req_ready = owner_oh;
        sta       = ~kind_q;
        sta40     = kind_q;
        state_nxt = WAIT;
      end
      WAIT:  if (cmd_rdy || timeout_hit) state_nxt = DONE;
      DONE: begin
        done      = ok_q ? owner_oh : '0;
        err       = ok_q ? '0 : owner_oh;
        abort     = ~ok_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner capture, round-robin pointer and response timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= PTR_RST;
      cnt      <= '0;
      kind_q   <= 1'b0;
      ok_q     <= 1'b0;
      readit_q <= 1'b0;
      init_q   <= 1'b0;
      cmd_q    <= '0;
      arg_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          owner    <= win;
          rr_ptr   <= win;
          kind_q   <= req_kind[win];
          readit_q <= req_readit[win];
          init_q   <= req_init[win];
          cmd_q    <= req_cmd[int'(win)*CMD_W +: CMD_W];
          arg_q    <= req_arg[int'(win)*ARG_W +: ARG_W];
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (cmd_rdy || timeout_hit) begin
            // cmd_rdy takes precedence over a coincident timeout
            ok_q     <= cmd_rdy;
            readit_q <= 1'b0;
            init_q   <= 1'b0;
            cmd_q    <= '0;
            arg_q    <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench: a round-robin NCH=3 instance and a fixed-priority NCH=2
// instance, both with an 8-cycle response timeout.
module tb_sd_cmd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // round-robin instance
  logic [2:0]  rv, rkind, rread, rinit;
  logic [17:0] rcmd;
  logic [95:0] rarg;
  logic        rrdy;
  logic [2:0]  r_ready, r_done, r_err;
  logic [5:0]  r_cmd;
  logic [31:0] r_arg;
  logic        r_sta, r_sta40, r_readit, r_init, r_abort, r_busy;

  // fixed-priority instance
  logic [1:0]  fv, fkind, fread, finit;
  logic [11:0] fcmd;
  logic [63:0] farg;
  logic        frdy;
  logic [1:0]  f_ready, f_done, f_err;
  logic [5:0]  f_cmd;
  logic [31:0] f_arg;
  logic        f_sta, f_sta40, f_readit, f_init, f_abort, f_busy;

  sd_cmd_arbiter #(.NCH(3), .CMD_W(6), .ARG_W(32), .ARB_MODE(1), .TIMEOUT(8)) u_rr (
    .clk(clk), .rst(rst), .req_valid(rv), .req_cmd(rcmd), .req_arg(rarg),
    .req_kind(rkind), .req_readit(rread), .req_init(rinit),
    .req_ready(r_ready), .done(r_done), .err(r_err), .cmd(r_cmd), .arg(r_arg),
    .sta(r_sta), .sta40(r_sta40), .readit(r_readit), .init(r_init),
    .abort(r_abort), .busy(r_busy), .cmd_rdy(rrdy));

  sd_cmd_arbiter #(.NCH(2), .CMD_W(6), .ARG_W(32), .ARB_MODE(0), .TIMEOUT(8)) u_fp (
    .clk(clk), .rst(rst), .req_valid(fv), .req_cmd(fcmd), .req_arg(farg),
    .req_kind(fkind), .req_readit(fread), .req_init(finit),
    .req_ready(f_ready), .done(f_done), .err(f_err), .cmd(f_cmd), .arg(f_arg),
    .sta(f_sta), .sta40(f_sta40), .readit(f_readit), .init(f_init),
    .abort(f_abort), .busy(f_busy), .cmd_rdy(frdy));

  typedef struct {
    logic [2:0]  v;
    logic        r;
    logic [2:0]  ready;
    logic [2:0]  done;
    logic        sta;
    logic        busy;
    logic        readit;
    logic [5:0]  cmd;
    logic [31:0] arg;
  } vec_t;

  vec_t tbl[9];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [53:0] rr_vec();
    return {r_ready, r_done, r_err, r_sta, r_sta40, r_abort, r_busy,
            r_readit, r_init, r_cmd, r_arg};
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input logic r, input logic [2:0] ready,
                              input logic [2:0] dn, input logic s, input logic b,
                              input logic rd, input logic [5:0] c, input logic [31:0] a);
    vec_t t;
    t.v = v; t.r = r; t.ready = ready; t.done = dn; t.sta = s;
    t.busy = b; t.readit = rd; t.cmd = c; t.arg = a;
    return t;
  endfunction

  // Advance one edge, drive the inputs for the new cycle, sample on the falling edge.
  task automatic step(input logic [2:0] v, input logic r);
    @(posedge clk); #1;
    rv = v; rrdy = r;
    @(negedge clk);
  endtask

  task automatic fstep(input logic [1:0] v, input logic r);
    @(posedge clk); #1;
    fv = v; frdy = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; rrdy = 1'b0; fv = '0; frdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] ecmd[3];
  logic [2:0] eo;
  int         ech, waits;
  logic       found, got_end;

  initial begin
    rcmd  = {6'd40, 6'd17, 6'd5};
    rarg  = {32'h0000_00C2, 32'h0000_0200, 32'h0000_00A0};
    rread = 3'b010;
    rinit = 3'b100;
    rkind = 3'b000;
    fcmd  = {6'd9, 6'd8};
    farg  = {32'h11, 32'h22};
    fkind = 2'b00; fread = 2'b00; finit = 2'b00;
    ecmd[0] = 6'd5; ecmd[1] = 6'd17; ecmd[2] = 6'd40;

    // single channel: ch1 CMD17, cmd_rdy five cycles after sta
    tbl[0] = mk(3'b010, 0, 3'b000, 3'b000, 0, 0, 0, 6'd0,  32'h0);
    tbl[1] = mk(3'b010, 0, 3'b010, 3'b000, 1, 1, 1, 6'd17, 32'h200);
    tbl[2] = mk(3'b000, 0, 3'b000, 3'b000, 0, 1, 1, 6'd17, 32'h200);
    tbl[3] = mk(3'b000, 0, 3'b000, 3'b000, 0, 1, 1, 6'd17, 32'h200);
    tbl[4] = mk(3'b000, 0, 3'b000, 3'b000, 0, 1, 1, 6'd17, 32'h200);
    tbl[5] = mk(3'b000, 0, 3'b000, 3'b000, 0, 1, 1, 6'd17, 32'h200);
    tbl[6] = mk(3'b000, 1, 3'b000, 3'b000, 0, 1, 1, 6'd17, 32'h200);
    tbl[7] = mk(3'b000, 0, 3'b000, 3'b010, 0, 1, 0, 6'd0,  32'h0);
    tbl[8] = mk(3'b000, 0, 3'b000, 3'b000, 0, 0, 0, 6'd0,  32'h0);

    do_reset();
    chk("reset_outputs", rr_vec(), 54'h0);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].r);
      chk($sformatf("single_row%0d", i), rr_vec(),
          {tbl[i].ready, tbl[i].done, 3'b000, tbl[i].sta, 1'b0, 1'b0, tbl[i].busy,
           tbl[i].readit, 1'b0, tbl[i].cmd, tbl[i].arg});
    end

    // round-robin: all channels held, expected order 0,1,2,0,1,2
    do_reset();
    step(3'b111, 0);
    for (int g = 0; g < 6; g++) begin
      ech = g % 3;
      eo  = 3'b001 << ech;
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        if (r_sta) found = 1'b1;
        else step(3'b111, 0);
      end
      chk($sformatf("rr_sta_seen%0d", g), found, 1);
      chk($sformatf("rr_grant%0d", g), r_ready, eo);
      chk($sformatf("rr_cmd%0d", g), r_cmd, ecmd[ech]);
      step(3'b111, 0);
      chk($sformatf("rr_ready_pulse%0d", g), r_ready, 0);
      step(3'b111, 1);
      step(3'b111, 0);
      chk($sformatf("rr_done%0d", g), {r_done, r_err}, {eo, 3'b000});
      step(3'b111, 0);
    end
    step(3'b000, 0);
    step(3'b000, 0);
    step(3'b000, 0);

    // fixed priority: ch0 wins every arbitration while both request
    do_reset();
    fstep(2'b11, 0);
    for (int g = 0; g < 3; g++) begin
      fstep(2'b11, 0);
      chk($sformatf("fp_grant%0d", g), {f_ready, f_sta}, {2'b01, 1'b1});
      fstep(2'b11, 1);
      fstep(2'b11, 0);
      chk($sformatf("fp_done%0d", g), {f_done, f_err}, {2'b01, 2'b00});
      fstep(2'b11, 0);
      chk($sformatf("fp_idle%0d", g), f_busy, 0);
    end
    fv = 2'b00;

    // timeout: sta40, cmd_rdy during ISSUE ignored, exactly 8 WAIT cycles
    do_reset();
    rkind = 3'b001;
    step(3'b001, 0);
    chk("to_idle_busy", r_busy, 0);
    step(3'b001, 1);
    chk("to_issue", {r_ready, r_sta, r_sta40}, {3'b001, 1'b0, 1'b1});
    waits = 0;
    got_end = 1'b0;
    for (int c = 0; c < 20 && !got_end; c++) begin
      step(3'b000, 0);
      if (r_err != 0 || r_done != 0) got_end = 1'b1;
      else waits++;
    end
    chk("to_wait_cycles", waits, 8);
    chk("to_err_abort", {r_err, r_done, r_abort}, {3'b001, 3'b000, 1'b1});
    step(3'b000, 0);
    chk("to_back_idle", {r_busy, r_abort, r_err}, 0);

    // tie: cmd_rdy on the 8th WAIT cycle wins over the timeout
    do_reset();
    rkind = 3'b001;
    step(3'b001, 0);
    step(3'b001, 0);
    for (int c = 0; c < 7; c++) step(3'b000, 0);
    step(3'b000, 1);
    chk("tie_wait8_busy", {r_busy, r_done, r_err}, {1'b1, 3'b000, 3'b000});
    step(3'b000, 0);
    chk("tie_done", {r_done, r_err, r_abort}, {3'b001, 3'b000, 1'b0});
    rkind = 3'b000;

    // reset mid-WAIT with ch1 as owner
    do_reset();
    step(3'b010, 0);
    step(3'b010, 0);
    chk("rst_owner_ch1", r_ready, 3'b010);
    step(3'b000, 0);
    step(3'b000, 0);
    chk("rst_in_wait", {r_busy, r_cmd}, {1'b1, 6'd17});
    #2 rst = 1'b1;
    #1 chk("rst_async_clear", rr_vec(), 54'h0);
    @(posedge clk); #1;
    chk("rst_held_clear", rr_vec(), 54'h0);
    @(negedge clk);
    rst = 1'b0;
    step(3'b111, 0);
    chk("rst_no_done_err", {r_done, r_err, r_busy}, 0);
    step(3'b111, 0);
    chk("rst_next_grant_ch0", {r_ready, r_cmd}, {3'b001, 6'd5});
    step(3'b000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
